// File: rtl/audio_pkg.sv
// Shared types and constants for the audio output path: sample width, gain scale,
// modulator feedback levels and the mute/unmute gain state encoding.
package audio_pkg;

    localparam int SAMPLE_W = 16;
    localparam logic [8:0] GAIN_UNITY = 9'd256;
    localparam logic signed [SAMPLE_W-1:0] FB_POS = 16'sh7FFF;
    localparam logic signed [SAMPLE_W-1:0] FB_NEG = 16'sh8000;

    typedef enum logic [1:0] {
        MUTED    = 2'd0,
        FADE_IN  = 2'd1,
        PLAY     = 2'd2,
        FADE_OUT = 2'd3
    } gain_state_e;

    // Offset binary to two's complement: flipping the MSB recentres 0x8000 on zero.
    function automatic logic signed [SAMPLE_W-1:0] offset_to_signed(input logic [SAMPLE_W-1:0] x);
        return $signed({~x[SAMPLE_W-1], x[SAMPLE_W-2:0]});
    endfunction

endpackage

// File: rtl/audio_pdm_out_sd2_modulator.sv
// Second-order 1-bit sigma-delta modulator. Both integrators clamp at their signed
// range limits so a full-scale input can never wrap them into the opposite polarity.
module sd2_modulator
    import audio_pkg::*;
(
    input  logic                       clk48,
    input  logic                       rst_n,
    input  logic signed [SAMPLE_W-1:0] v_i,
    output logic                       pdm_o
);

    localparam int I1_W = 20;
    localparam int I2_W = 24;
    localparam logic signed [I1_W+1:0] I1_MAX = $signed({3'b000, {(I1_W-1){1'b1}}});
    localparam logic signed [I1_W+1:0] I1_MIN = $signed({3'b111, {(I1_W-1){1'b0}}});
    localparam logic signed [I2_W+1:0] I2_MAX = $signed({3'b000, {(I2_W-1){1'b1}}});
    localparam logic signed [I2_W+1:0] I2_MIN = $signed({3'b111, {(I2_W-1){1'b0}}});

    function automatic logic signed [I1_W-1:0] sat_i1(input logic signed [I1_W+1:0] x);
        if (x > I1_MAX) return I1_W'(I1_MAX);
        if (x < I1_MIN) return I1_W'(I1_MIN);
        return I1_W'(x);
    endfunction

    function automatic logic signed [I2_W-1:0] sat_i2(input logic signed [I2_W+1:0] x);
        if (x > I2_MAX) return I2_W'(I2_MAX);
        if (x < I2_MIN) return I2_W'(I2_MIN);
        return I2_W'(x);
    endfunction

    logic signed [I1_W-1:0]     i1_q, i1_d;
    logic signed [I2_W-1:0]     i2_q, i2_d;
    logic                       pdm_q, pdm_d;
    logic signed [SAMPLE_W-1:0] fb;

    assign fb = pdm_q ? FB_POS : FB_NEG;

    // The second integrator takes the freshly updated first integrator, giving the
    // classic (1 - z^-1)^2 noise shaping with a one-clock signal delay.
    always_comb begin
        i1_d  = sat_i1((I1_W+2)'(i1_q) + (I1_W+2)'(v_i) - (I1_W+2)'(fb));
        i2_d  = sat_i2((I2_W+2)'(i2_q) + (I2_W+2)'(i1_d) - (I2_W+2)'(fb));
        pdm_d = ~i2_d[I2_W-1];
    end

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            i1_q  <= '0;
            i2_q  <= '0;
            pdm_q <= 1'b0;
        end else begin
            i1_q  <= i1_d;
            i2_q  <= i2_d;
            pdm_q <= pdm_d;
        end
    end

    assign pdm_o = pdm_q;

endmodule

// File: rtl/audio_pdm_out.sv
// Mixer output stage: linear interpolation of the per-period sample to clock rate,
// click-free gain ramp on mute/unmute, and a second-order sigma-delta pin driver.
module audio_pdm_out
    import audio_pkg::*;
#(
    parameter int PERIOD_LOG2 = 10,
    parameter int FADE_LOG2   = 8
) (
    input  logic                clk48,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    input  logic                mute,
    output logic                pdm_out,
    output logic                muted
);

    localparam int ACC_W = PERIOD_LOG2 + 17;
    localparam int ACC_X = ACC_W + 1;
    localparam logic [FADE_LOG2-1:0] TIMER_MAX = '1;

    logic signed [SAMPLE_W-1:0] prev_q, prev_d;
    logic signed [SAMPLE_W-1:0] target_q, target_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [16:0]         delta;
    logic signed [ACC_W-1:0]    acc_lim;
    logic signed [ACC_X-1:0]    acc_sum;
    logic                       acc_over;
    logic signed [SAMPLE_W-1:0] interp;

    gain_state_e                state_q, state_d;
    logic [8:0]                 gain_q, gain_d;
    logic [FADE_LOG2-1:0]       timer_q, timer_d;
    logic                       wrap;

    logic signed [25:0]         prod;
    logic signed [SAMPLE_W-1:0] v;

    // The ramp is prev + delta * k / 2**PERIOD_LOG2; clamping acc at the full step
    // makes a late strobe hold the target instead of overshooting it.
    assign delta    = 17'(target_q) - 17'(prev_q);
    assign acc_lim  = ACC_W'(delta) <<< PERIOD_LOG2;
    assign acc_sum  = ACC_X'(acc_q) + ACC_X'(delta);
    assign acc_over = delta[16] ? (acc_sum < ACC_X'(acc_lim)) : (acc_sum > ACC_X'(acc_lim));
    assign interp   = prev_q + SAMPLE_W'(acc_q >>> PERIOD_LOG2);

    always_comb begin
        prev_d   = prev_q;
        target_d = target_q;
        acc_d    = acc_over ? acc_lim : ACC_W'(acc_sum);
        if (sample_valid) begin
            prev_d   = interp;
            target_d = offset_to_signed(sample_in);
            acc_d    = '0;
        end
    end

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            prev_q   <= '0;
            target_q <= '0;
            acc_q    <= '0;
        end else begin
            prev_q   <= prev_d;
            target_q <= target_d;
            acc_q    <= acc_d;
        end
    end

    assign wrap = (timer_q == TIMER_MAX);

    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        timer_d = timer_q + FADE_LOG2'(1);
        unique case (state_q)
            MUTED: begin
                gain_d  = '0;
                timer_d = '0;
                if (!mute) state_d = FADE_IN;
            end
            FADE_IN: begin
                if (mute) begin
                    state_d = FADE_OUT;
                    timer_d = '0;
                end else if (gain_q == GAIN_UNITY) begin
                    state_d = PLAY;
                    timer_d = '0;
                end else if (wrap) begin
                    gain_d = gain_q + 9'd1;
                    if (gain_q == GAIN_UNITY - 9'd1) state_d = PLAY;
                end
            end
            PLAY: begin
                gain_d  = GAIN_UNITY;
                timer_d = '0;
                if (mute) state_d = FADE_OUT;
            end
            FADE_OUT: begin
                // Reversal keeps the current gain so the level never jumps.
                if (!mute) begin
                    state_d = FADE_IN;
                    timer_d = '0;
                end else if (gain_q == '0) begin
                    state_d = MUTED;
                    timer_d = '0;
                end else if (wrap) begin
                    gain_d = gain_q - 9'd1;
                    if (gain_q == 9'd1) state_d = MUTED;
                end
            end
            default: begin
                state_d = MUTED;
                gain_d  = '0;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MUTED;
            gain_q  <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
            timer_q <= timer_d;
        end
    end

    assign muted = (state_q == MUTED);

    // Gain is Q1.8 with 256 as unity, so full gain passes interp bit-exact.
    assign prod = 26'(interp) * 26'($signed({1'b0, gain_q}));
    assign v    = SAMPLE_W'(prod >>> 8);

    sd2_modulator u_mod (
        .clk48 (clk48),
        .rst_n (rst_n),
        .v_i   (v),
        .pdm_o (pdm_out)
    );

endmodule
